// File: rtl/spi_sram_target.sv
// SPI byte-addressable SRAM target (03 read / 02 write, 24-bit address, sequential wrap).
// All SPI inputs are oversampled by clk; sclk edges become single-clk strobes.
module spi_sram_target #(
  parameter int          ADDR_BITS = 10,
  parameter logic [7:0]  INIT_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 ce,
  input  logic                 si,
  output logic                 so,
  output logic                 so_oe,
  output logic                 busy,
  output logic                 cmd_err,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]           dbg_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE
  } state_t;

  logic [1:0]           r_sclk_s, r_ce_s, r_si_s;
  logic                 r_sclk_d, r_ce_d;
  logic [1:0]           r_warm;
  logic                 r_armed;
  state_t               r_state;
  logic [2:0]           r_cnt;
  logic [1:0]           r_abyte;
  logic [ADDR_BITS-1:0] r_addr;
  logic [6:0]           r_sh;
  logic                 r_rd;
  logic                 r_so, r_so_oe, r_cmd_err;
  logic [7:0]           r_mem [0:DEPTH-1];

  logic                 w_sclk, w_ce, w_si, w_rise, w_fall, w_ce_rise;
  logic [7:0]           w_byte;
  logic [2:0]           w_cnt_dec;
  logic [ADDR_BITS-1:0] w_addr_inc;
  state_t               w_state_n;
  logic [2:0]           w_cnt_n;
  logic [1:0]           w_abyte_n;
  logic [ADDR_BITS-1:0] w_addr_n;
  logic [6:0]           w_sh_n;
  logic                 w_rd_n, w_so_n, w_so_oe_n, w_cmd_err_n, w_we;

  assign w_sclk     = r_sclk_s[1];
  assign w_ce       = r_ce_s[1];
  assign w_si       = r_si_s[1];
  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_fall     = ~w_sclk & r_sclk_d;
  // A ce that was already high when reset released must be seen low before it counts.
  assign w_ce_rise  = w_ce & ~r_ce_d & r_armed;
  assign w_byte     = {r_sh, w_si};
  assign w_cnt_dec  = r_cnt - 3'd1;
  assign w_addr_inc = r_addr + ADDR_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s <= '0;
      r_ce_s   <= '0;
      r_si_s   <= '0;
      r_sclk_d <= 1'b0;
      r_ce_d   <= 1'b0;
      r_warm   <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_ce_s   <= {r_ce_s[0], ce};
      r_si_s   <= {r_si_s[0], si};
      r_sclk_d <= w_sclk;
      r_ce_d   <= w_ce;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      if (r_warm == 2'd2 && !w_ce) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd7;
      r_abyte   <= '0;
      r_addr    <= '0;
      r_sh      <= '0;
      r_rd      <= 1'b0;
      r_so      <= 1'b0;
      r_so_oe   <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_abyte   <= w_abyte_n;
      r_addr    <= w_addr_n;
      r_sh      <= w_sh_n;
      r_rd      <= w_rd_n;
      r_so      <= w_so_n;
      r_so_oe   <= w_so_oe_n;
      r_cmd_err <= w_cmd_err_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_abyte_n   = r_abyte;
    w_addr_n    = r_addr;
    w_sh_n      = r_sh;
    w_rd_n      = r_rd;
    w_so_n      = r_so;
    w_so_oe_n   = r_so_oe;
    w_cmd_err_n = 1'b0;
    w_we        = 1'b0;
    if (r_state != IDLE && !w_ce) begin
      w_state_n = IDLE;
      w_cnt_n   = 3'd7;
      w_so_n    = 1'b0;
      w_so_oe_n = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_ce_rise) begin
          w_state_n = CMD;
          w_cnt_n   = 3'd7;
          w_abyte_n = '0;
        end
        CMD: if (w_rise) begin
          w_sh_n  = w_byte[6:0];
          w_cnt_n = w_cnt_dec;
          if (r_cnt == 3'd0) begin
            case (w_byte)
              8'h03:   begin w_state_n = ADDR; w_rd_n = 1'b1; end
              8'h02:   begin w_state_n = ADDR; w_rd_n = 1'b0; end
              default: begin w_state_n = IGNORE; w_cmd_err_n = 1'b1; end
            endcase
          end
        end
        ADDR: if (w_rise) begin
          // Shifting all 24 bits through keeps only the low ADDR_BITS.
          w_addr_n = {r_addr[ADDR_BITS-2:0], w_si};
          w_cnt_n  = w_cnt_dec;
          if (r_cnt == 3'd0) begin
            w_abyte_n = r_abyte + 2'd1;
            if (r_abyte == 2'd2) w_state_n = r_rd ? DUMMY : WRITE;
          end
        end
        DUMMY: begin
          if (w_fall) begin
            w_so_oe_n = 1'b1;
            w_so_n    = r_mem[r_addr][7];
            w_cnt_n   = 3'd7;
          end else if (w_rise && r_so_oe) begin
            w_state_n = READ;
          end
        end
        READ: if (w_fall) begin
          // r_cnt is the index of the bit currently on so.
          if (r_cnt == 3'd0) begin
            w_addr_n = w_addr_inc;
            w_so_n   = r_mem[w_addr_inc][7];
            w_cnt_n  = 3'd7;
          end else begin
            w_so_n  = r_mem[r_addr][w_cnt_dec];
            w_cnt_n = w_cnt_dec;
          end
        end
        WRITE: if (w_rise) begin
          w_sh_n  = w_byte[6:0];
          w_cnt_n = w_cnt_dec;
          if (r_cnt == 3'd0) begin
            w_we     = 1'b1;
            w_addr_n = w_addr_inc;
          end
        end
        IGNORE: ;
        default: begin
          w_state_n = IDLE;
          w_so_n    = 1'b0;
          w_so_oe_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_BYTE;
    end else if (w_we) begin
      r_mem[r_addr] <= w_byte;
    end
  end

  assign so       = r_so & r_so_oe;
  assign so_oe    = r_so_oe;
  assign busy     = (r_state != IDLE);
  assign cmd_err  = r_cmd_err;
  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: doc/spi_sram_target.md
SPI_SRAM_TARGET -- requirements
Module: spi_sram_target

Interface
REQ-001 Parameter ADDR_BITS, default 10, sets internal byte-array depth to 2**ADDR_BITS.
REQ-002 Parameter INIT_BYTE, default 8'h00, is the reset value of every array byte.
REQ-003 clk  input  1  single block clock; the SHALL-level requirement is fclk >= 8x fsclk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the initiator, asynchronous to clk.
REQ-006 ce  input  1  chip enable, active high; a transaction is framed by ce high.
REQ-007 si  input  1  serial data from the initiator, MSB first.
REQ-008 so  output  1  serial data to the initiator, MSB first.
REQ-009 so_oe  output  1  high while so carries read data.
REQ-010 busy  output  1  high while a transaction is in progress (state != IDLE).
REQ-011 cmd_err  output  1  one-clk pulse on an unsupported command byte.
REQ-012 dbg_addr  input  ADDR_BITS  backdoor read address.
REQ-013 dbg_data  output  8  combinational array[dbg_addr], for the bench only.

Function
REQ-014 sclk, ce and si shall each pass through a 2-flop synchronizer; sclk rise and fall are detected from the synchronized samples, one clk pulse each.
REQ-015 si shall be sampled on a detected sclk rise only; so shall change on a detected sclk fall only.
REQ-016 The FSM states shall be IDLE, CMD, ADDR, DUMMY, READ, WRITE and IGNORE.
REQ-017 A synchronized ce rise in IDLE shall enter CMD with bit counter = 7.
REQ-018 CMD shall shift 8 bits. On the 8th rise:
- 8'h03 enters ADDR with read mode.
- 8'h02 enters ADDR with write mode.
- Any other value enters IGNORE and pulses cmd_err.
REQ-019 ADDR shall shift 24 bits MSB first. Only bits [ADDR_BITS-1:0] are retained; upper bits are ignored.
REQ-020 On the 24th address rise, write mode shall enter WRITE and read mode shall enter DUMMY.
REQ-021 DUMMY read timing:
- At the next detected fall, so_oe = 1 and so = bit 7 of array[addr].
- At the following rise, the FSM enters READ.
REQ-022 READ shall advance so to the next lower bit at each detected fall. After bit 0 has been presented, the next fall presents bit 7 of array[addr+1], and addr increments.
REQ-023 WRITE shall shift 8 bits per byte on rises. On the 8th rise, the byte is written to array[addr] in that clk, and addr increments.
REQ-024 Address increment shall wrap modulo 2**ADDR_BITS (sequential mode, no page boundary).
REQ-025 A synchronized ce fall in any state shall return the FSM to IDLE within 1 clk:
- A partial write byte is discarded; the array is unchanged by it.
- so_oe = 0 and so = 0.
REQ-026 IGNORE shall hold so_oe = 0 and ignore sclk until ce falls.
REQ-027 When ce rise and sclk rise are detected in the same clk, the ce event shall take priority; that sclk rise is not counted.
REQ-028 so shall be 0 whenever so_oe = 0.
REQ-029 Bit counter and address registers shall not overflow into adjacent fields; the counter is 3 bits and the address is ADDR_BITS bits.

Reset
REQ-030 Asserting reset at any time, including mid-transaction, shall force the following regardless of clk or sclk activity:
- State IDLE.
- so = 0, so_oe = 0, busy = 0, cmd_err = 0.
- Bit counter = 7, addr = 0.
- Synchronizer flops = 0.
- All array bytes = INIT_BYTE.
REQ-031 After reset deassert, the first transaction shall require a fresh ce rise. A ce already high at deassert shall be treated as an active transaction start only once it has been seen low.

Verification
REQ-032 Write then read: write 02 000010 DEADBEEF; then read 03 000010 with a 1-bit dummy and 32 data clocks. Required: so returns DE AD BE EF; dbg_data at 0x10..0x13 = DE, AD, BE, EF.
REQ-033 Wrap: with ADDR_BITS = 10, write 02 0003FF A5 5A. Required: array[0x3FF] = A5 and array[0x000] = 5A.
REQ-034 Abort: write 02 000020, send 5 bits of a byte, then drop ce. Required: array[0x20] keeps INIT_BYTE; busy falls within 3 clk of the ce fall; the next transaction works normally.
REQ-035 Bad command: command 8'h9F. Required: one cmd_err pulse; so_oe stays 0 until the ce fall; array unchanged.
REQ-036 Reset mid-read: reset asserted during READ. Required: so_oe = 0 and busy = 0 immediately; the array is reinitialized to INIT_BYTE.
REQ-037 Initiator interop: spi_master in slow_mode on a clk 4x slower than the target clk, with byte_mask 2'b00 (1 byte) and 2'b10 (4 bytes). Required: data_out matches the bytes previously written, for both masks.
